// File: rtl/fib_seq_engine.sv
// fib_seq_engine: seeded Fibonacci-style term generator with valid/ready output,
// programmable term count and per-term overflow tracking (wrap or stop).
module fib_seq_engine #(
    parameter int WIDTH  = 16,
    parameter int SEED_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              start,
    input  logic [CNT_W-1:0]  term_count,
    input  logic              mode,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] seed_a, seed_b, cur, nxt, a_next, b_next;
    logic [CNT_W-1:0] cnt, cnt_max;
    logic [WIDTH:0] sum;
    logic mode_q, cur_bad, nxt_bad, ovf_q;
    // Loads take effect before a same-cycle start so the run sees the new seed.
    assign a_next = load_a ? WIDTH'(seed_in) : seed_a;
    assign b_next = load_b ? WIDTH'(seed_in) : seed_b;
    assign sum = {1'b0, cur} + {1'b0, nxt};
    assign out_data = cur;
    assign out_valid = (state == EMIT) && !(cur_bad && mode_q);
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign overflow = ovf_q || ((state == EMIT) && cur_bad);
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            seed_a  <= '0;
            seed_b  <= WIDTH'(1);
            cur     <= '0;
            nxt     <= '0;
            cnt     <= '0;
            cnt_max <= '0;
            mode_q  <= 1'b0;
            cur_bad <= 1'b0;
            nxt_bad <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    seed_a <= a_next;
                    seed_b <= b_next;
                    if (start) begin
                        cnt_max <= term_count;
                        mode_q  <= mode;
                        ovf_q   <= 1'b0;
                        cnt     <= '0;
                        cur     <= a_next;
                        nxt     <= b_next;
                        cur_bad <= 1'b0;
                        nxt_bad <= 1'b0;
                        state   <= (term_count == '0) ? DONE : EMIT;
                    end
                end
                EMIT: begin
                    if (cur_bad)
                        ovf_q <= 1'b1;
                    if (cur_bad && mode_q) begin
                        state <= DONE;
                    end else if (out_ready) begin
                        cnt     <= cnt + 1'b1;
                        cur     <= nxt;
                        cur_bad <= nxt_bad;
                        nxt     <= sum[WIDTH-1:0];
                        nxt_bad <= sum[WIDTH] | cur_bad | nxt_bad;
                        if (cnt == cnt_max - 1'b1)
                            state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: scoreboard bench; stimulus queues expected {overflow,term},
// a negedge monitor pops and compares on every handshake.
module tb_fib_seq_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] seed_in = '0;
    logic       load_a = 1'b0, load_b = 1'b0, start = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [7:0] term_count = '0;
    logic [7:0] out_data;
    logic       out_valid, busy, done, overflow;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [7:0] prev_data = '0;
    logic       prev_stall = 1'b0;
    logic       ovf_at_done, done_seen;
    int checks = 0, errors = 0, acc_cnt = 0;

    fib_seq_engine #(.WIDTH(8), .SEED_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .seed_in(seed_in), .load_a(load_a), .load_b(load_b),
        .start(start), .term_count(term_count), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%0b data=%0d required valid=1 data=%0d", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_term got %0d required none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({overflow, out_data} !== e) begin
                        errors++;
                        $display("FAIL term got ovf=%0b data=%0d required ovf=%0b data=%0d", overflow, out_data, e[8], e[7:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic ovf, input logic [7:0] d);
        exp_q.push_back({ovf, d});
    endtask

    task automatic issue(input logic [7:0] tc, input logic m);
        term_count = tc;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle, or after the bound expires.
    task automatic run(input int bound, input bit stall_pat);
        done_seen = 1'b0;
        ovf_at_done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            out_ready = stall_pat ? (i % 3 == 0) : 1'b1;
            @(negedge clk);
            if (done) begin
                done_seen = 1'b1;
                ovf_at_done = overflow;
                break;
            end
            tick();
        end
        chk("done_seen", done_seen, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int fib8[20] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98, 219, 61, 24, 85};
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);

        // Fibonacci at full throughput
        tick();
        for (int i = 0; i < 8; i++) push(1'b0, 8'(fib8[i]));
        out_ready = 1'b1;
        issue(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_valid_consecutive", out_valid, 1);
        end
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_busy_in_done", busy, 1);
        chk("t1_ovf", overflow, 0);
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);
        chk("t1_done_fall", done, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Lucas seeds with back-pressure
        tick();
        seed_in = 4'd2;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        seed_in = 4'd1;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        push(1'b0, 8'd2); push(1'b0, 8'd1); push(1'b0, 8'd3); push(1'b0, 8'd4); push(1'b0, 8'd7);
        issue(5, 1'b0);
        run(40, 1'b1);
        chk("t2_ovf", ovf_at_done, 0);

        // Stop on overflow
        tick();
        do_reset();
        for (int i = 0; i < 14; i++) push(1'b0, 8'(fib8[i]));
        acc_cnt = 0;
        out_ready = 1'b1;
        issue(20, 1'b1);
        run(40, 1'b0);
        chk("t3_ovf_with_done", ovf_at_done, 1);
        chk("t3_accepted", acc_cnt, 14);

        // Wrap on overflow
        tick();
        for (int i = 0; i < 20; i++) push(i >= 14, 8'(fib8[i]));
        acc_cnt = 0;
        issue(20, 1'b0);
        run(40, 1'b0);
        chk("t4_ovf_with_done", ovf_at_done, 1);
        chk("t4_accepted", acc_cnt, 20);

        // Empty run; a start during DONE is ignored
        tick();
        acc_cnt = 0;
        term_count = 8'd0;
        mode = 1'b0;
        start = 1'b1;
        tick();
        term_count = 8'd3;
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 1);
        chk("t5_ovf_cleared", overflow, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t5_busy_after", busy, 0);
        chk("t5_valid_after", out_valid, 0);
        tick();
        @(negedge clk);
        chk("t5_valid_later", out_valid, 0);
        chk("t5_accepted", acc_cnt, 0);

        // Reset mid-stall, then seeds restored and busy loads ignored
        tick();
        seed_in = 4'd9;
        load_a = 1'b1;
        load_b = 1'b1;
        tick();
        load_a = 1'b0;
        load_b = 1'b0;
        out_ready = 1'b0;
        issue(10, 1'b0);
        @(negedge clk);
        chk("t6_stall_valid", out_valid, 1);
        chk("t6_seed_a_both", out_data, 9);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", overflow, 0);
        tick();
        push(1'b0, 8'd0); push(1'b0, 8'd1); push(1'b0, 8'd1);
        out_ready = 1'b1;
        issue(3, 1'b0);
        seed_in = 4'd7;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        run(20, 1'b0);
        tick();
        push(1'b0, 8'd0); push(1'b0, 8'd1);
        issue(2, 1'b0);
        run(20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end
endmodule
